// File: rtl/jt12_wr_sched.sv
// CPU-side write scheduler: captures host address/data writes, waits for the
// core slot-sync point, issues one register-file strobe and holds busy.
module jt12_wr_sched #(
  parameter int BUSY_CNT = 32,
  parameter int CW       = 6
) (
  input  logic       rst_n,
  input  logic       clk,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       zero,
  output logic [7:0] reg_addr,
  output logic       reg_part,
  output logic [7:0] reg_din,
  output logic       reg_we,
  output logic       busy,
  output logic       dropped
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          wr_act_s;
  logic          wr_ev_s;
  logic          addr_ev_s;
  logic          data_ev_s;
  logic          wr_act_r;
  logic [7:0]    lat_addr_r;
  logic          lat_part_r;
  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;

  assign wr_act_s  = !cs_n && !wr_n;
  assign wr_ev_s   = wr_act_s && !wr_act_r;
  assign addr_ev_s = wr_ev_s && !addr[0];
  assign data_ev_s = wr_ev_s && addr[0];

  // Previous strobe level for rising-edge detection on the raw CPU clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_r <= 1'b0;
    end else begin
      wr_act_r <= wr_act_s;
    end
  end

  // Address latch is independent of the scheduler state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr_r <= 8'd0;
      lat_part_r <= 1'b0;
    end else if (addr_ev_s) begin
      lat_addr_r <= din;
      lat_part_r <= addr[1];
    end else begin
      lat_addr_r <= lat_addr_r;
      lat_part_r <= lat_part_r;
    end
  end

  // Scheduler FSM; a data write is only ever accepted from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      reg_addr <= 8'd0;
      reg_part <= 1'b0;
      reg_din  <= 8'd0;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      dropped <= data_ev_s && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          reg_we <= 1'b0;
          if (data_ev_s) begin
            reg_addr <= lat_addr_r;
            reg_part <= lat_part_r;
            reg_din  <= din;
            busy     <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cen && zero) begin
            reg_we  <= 1'b1;
            state_r <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (cen) begin
            reg_we  <= 1'b0;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // busy falls on the cen tick that finds the counter already at zero
          if (cen) begin
            if (cnt_r == CNT_ZERO) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
        default: begin
          reg_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Randomized bench for jt12_wr_sched against a tick-counting behavioural model.
module tb_jt12_wr_sched;

  localparam int N = 32;

  logic       rst_n = 1'b0;
  logic       clk = 1'b0;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'd0;
  logic       zero = 1'b0;
  logic [7:0] reg_addr;
  logic       reg_part;
  logic [7:0] reg_din;
  logic       reg_we;
  logic       busy;
  logic       dropped;

  jt12_wr_sched #(.BUSY_CNT(N), .CW(6)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .zero(zero), .reg_addr(reg_addr),
    .reg_part(reg_part), .reg_din(reg_din), .reg_we(reg_we),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Model: a write is "in flight" from acceptance until N+1 cen ticks after
  // the zero&cen tick that fired its strobe; k counts cen ticks since then.
  logic [7:0] m_lat_addr, m_addr, m_din;
  logic       m_lat_part, m_part;
  logic       m_act, m_inflight, m_strobed, m_drop;
  int         m_k;

  task automatic model_reset();
    m_lat_addr = 8'd0; m_lat_part = 1'b0; m_addr = 8'd0; m_part = 1'b0;
    m_din = 8'd0; m_act = 1'b0; m_inflight = 1'b0; m_strobed = 1'b0;
    m_drop = 1'b0; m_k = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    logic ev, was;
    if (!rst_n) begin
      model_reset();
    end else begin
      ev = (!cs_n && !wr_n) && !m_act;
      m_act = !cs_n && !wr_n;
      was = m_inflight;
      m_drop = 1'b0;
      if (m_inflight) begin
        if (m_strobed) begin
          if (cen) begin
            m_k++;
            if (m_k == N + 1) begin
              m_inflight = 1'b0;
              m_strobed = 1'b0;
            end
          end
        end else if (cen && zero) begin
          m_strobed = 1'b1;
          m_k = 0;
        end
      end
      if (ev) begin
        if (!addr[0]) begin
          m_lat_addr = din;
          m_lat_part = addr[1];
        end else if (!was) begin
          m_addr = m_lat_addr;
          m_part = m_lat_part;
          m_din = din;
          m_inflight = 1'b1;
        end else begin
          m_drop = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("reg_addr", reg_addr, m_addr);
      chk("reg_part", {7'd0, reg_part}, {7'd0, m_part});
      chk("reg_din", reg_din, m_din);
      chk("reg_we", {7'd0, reg_we}, {7'd0, (m_strobed && m_k == 0)});
      chk("busy", {7'd0, busy}, {7'd0, m_inflight});
      chk("dropped", {7'd0, dropped}, {7'd0, m_drop});
    end
  end

  // cen/zero generator: mode 0 = cen every 2 clk with zero every 24 cen,
  // mode 1 = cen frozen low, mode 2 = random cen and zero.
  int cen_mode = 0;
  int cen_ph = 0;
  int tick = 0;
  always @(negedge clk) begin
    case (cen_mode)
      0: begin
        cen_ph = 1 - cen_ph;
        cen = (cen_ph == 1);
        if (cen) tick++;
        zero = cen && (tick % 24 == 0);
      end
      1: begin
        cen = 1'b0;
        zero = 1'b0;
      end
      default: begin
        cen = ($urandom_range(0, 1) == 1);
        zero = ($urandom_range(0, 7) == 0);
      end
    endcase
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_we();
    int n = 0;
    while (reg_we !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("we_timeout", {7'd0, (n < 3000)}, 8'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {7'd0, (n < 3000)}, 8'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cs_n = 1'b1; wr_n = 1'b1;
    model_reset();
    #1;
    chk("rst_addr", reg_addr, 8'd0);
    chk("rst_part", {7'd0, reg_part}, 8'd0);
    chk("rst_din", reg_din, 8'd0);
    chk("rst_we", {7'd0, reg_we}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_dropped", {7'd0, dropped}, 8'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (4) @(negedge clk);

    // Basic write plus an address write landing while the first is pending
    wr(2'b00, 8'h28, 1);
    wr(2'b01, 8'hF0, 1);
    wr(2'b00, 8'hA4, 1);
    wait_we();
    chk("basic_addr", reg_addr, 8'h28);
    chk("basic_part", {7'd0, reg_part}, 8'd0);
    chk("basic_din", reg_din, 8'hF0);
    repeat (10) @(negedge clk);
    wr(2'b01, 8'h55, 1);
    repeat (3) @(negedge clk);
    chk("din_kept", reg_din, 8'hF0);
    wait_idle();
    wr(2'b01, 8'h3C, 1);
    wait_we();
    chk("late_addr", reg_addr, 8'hA4);
    wait_idle();

    // Bank select, then freeze cen in HOLD
    wr(2'b10, 8'h30, 1);
    wr(2'b11, 8'h71, 1);
    wait_we();
    chk("bank_part", {7'd0, reg_part}, 8'd1);
    chk("bank_addr", reg_addr, 8'h30);
    chk("bank_din", reg_din, 8'h71);
    repeat (6) @(negedge clk);
    cen_mode = 1;
    repeat (100) @(negedge clk);
    chk("frozen_busy", {7'd0, busy}, 8'd1);
    cen_mode = 0;
    wait_idle();

    // Held strobe must give a single event
    wr(2'b01, 8'h22, 10);
    wait_idle();

    // Reset in the middle of HOLD
    wr(2'b01, 8'h99, 1);
    wait_we();
    repeat (8) @(negedge clk);
    do_reset();
    repeat (200) @(negedge clk);

    cen_mode = 2;
    for (int i = 0; i < 400; i++) begin
      wr(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(1, 4));
      repeat ($urandom_range(1, 30)) @(negedge clk);
      if (i == 200) do_reset();
    end
    cen_mode = 0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
